pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It drives the hold/bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards between ID and EX, and holds the pipeline while a multi-cycle EX operation (mult/div) runs. An exception flush from MEM overrides all stalls.

## Interface
Parameters:
- CNT_W, 6, width of the multi-cycle length field and the internal down-counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- id_rs_addr  in  5  rs register index of the instruction in ID.
- id_rt_addr  in  5  rt register index of the instruction in ID.
- id_rs_read  in  1  ID instruction reads rs.
- id_rt_read  in  1  ID instruction reads rt.
- ex_w_reg_addr  in  5  destination register of the instruction in EX.
- ex_wd  in  1  EX instruction writes a register.
- ex_is_load  in  1  EX instruction is a load.
- ex_multi_req  in  1  EX instruction needs ex_multi_cycles cycles in EX; held while that instruction stays in EX.
- ex_multi_cycles  in  CNT_W  total EX occupancy in cycles.
- excp_flush  in  1  exception in MEM; flush the pipeline.
- stall  out  5  hold enables: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.
- id_ex_bubble  out  1  ID/EX loads a NOP this edge.
- ex_mem_bubble  out  1  EX/MEM loads a NOP this edge.
- flush  out  1  clear all pipeline registers this edge.
- ex_multi_done  out  1  EX result of the multi-cycle op is valid this cycle.
- stall_cycles  out  32  saturating count of cycles with stall[0]=1.

## Operation
- **FSM states:** IDLE, BUSY, DONE. The down-counter cnt is CNT_W bits wide.
- **Entry from IDLE** (ex_multi_req=1, N=ex_multi_cycles):
  - N<=1: stay IDLE; ex_multi_done=1 in this cycle; no stall.
  - N=2: go to DONE.
  - N>=3: load cnt=N-3 and go to BUSY.
- **BUSY:** if cnt==0, go to DONE; otherwise decrement cnt.
- **DONE:** go to IDLE unconditionally. ex_multi_req is ignored in DONE because the same instruction is leaving EX.
- **Multi-cycle stall:** asserted during the IDLE entry cycle (when N>=2) and every BUSY cycle.
  - stall=5'b00111, ex_mem_bubble=1, id_ex_bubble=0.
  - In DONE: stall=0 and ex_multi_done=1.
  - The instruction therefore occupies EX for exactly N cycles.
- **Load-use hazard:** ex_is_load & ex_wd & (ex_w_reg_addr!=0) & ((id_rs_read & id_rs_addr==ex_w_reg_addr) | (id_rt_read & id_rt_addr==ex_w_reg_addr)).
  - Response: stall=5'b00011 and id_ex_bubble=1.
  - Only when no multi-cycle stall is active.
- **Priority:** flush > multi-cycle stall > load-use > none.
- **Flush** (excp_flush=1):
  - flush=1; stall, both bubbles and ex_multi_done are 0.
  - FSM goes to IDLE and cnt to 0 at the next edge, aborting any multi-cycle op.
- **Idle outputs:** with no condition active, stall=0 and both bubbles are 0.
- **stall_cycles:** increments on each edge where stall[0]=1 and flush=0. It holds at 32'hFFFF_FFFF.

## Timing
- **Combinational outputs:** stall, bubbles, flush and ex_multi_done are combinational from the current state and inputs. They are valid in the same cycle as the cause.
- **Registered state:** FSM, cnt and stall_cycles update on the rising edge of clk.
- **Reset:** while rst=0, asynchronously: FSM=IDLE, cnt=0, stall_cycles=0.
  - Output values with idle inputs: stall=0, id_ex_bubble=0, ex_mem_bubble=0, flush=0, ex_multi_done=0.
  - Reset mid-operation abandons the op with no done pulse.
- **Load-use latency:** the stall lasts exactly one cycle. After that edge the load has moved to MEM and the condition drops.
- **Multi-cycle latency:** stall cycles = N-1 for N>=2. ex_multi_done is high only in cycle N of the op.
- **Simultaneous events:**
  - excp_flush while in BUSY: flush wins that cycle; the FSM is IDLE next cycle.
  - ex_multi_req together with a load-use match: the multi-cycle stall wins.

## Test plan
- **Load-use:** ex_is_load=1, ex_wd=1, ex_w_reg_addr=8, id_rs_read=1, id_rs_addr=8 for one cycle -> stall=00011, id_ex_bubble=1 that cycle; stall_cycles=1 after the edge.
- **Load to $0:** same stimulus with ex_w_reg_addr=0 -> stall=0 and no bubble.
- **Multi-cycle N=5:** ex_multi_req held with ex_multi_cycles=5 -> stall=00111 with ex_mem_bubble=1 for cycles 1-4; ex_multi_done=1 in cycle 5 only, with stall=0; FSM is IDLE in cycle 6.
- **N=1 and N=2:** N=1 -> done in the same cycle, no stall. N=2 -> one stall cycle, then done.
- **Flush abort:** N=6, excp_flush=1 in cycle 3 -> flush=1, stall=0 that cycle; the next cycle is IDLE with no done; stall_cycles=2.
- **Reset:** rst=0 in the middle of BUSY -> outputs and stall_cycles go to 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hold/bubble/flush sequencer: load-use interlock, multi-cycle EX hold, MEM exception flush.
// Controls are combinational in the cycle of the cause; FSM, counter and stall_cycles register on clk.
// No handshake of its own: it produces the hold enables the pipeline obeys, and flush overrides every stall.
module pipe_ctrl #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_rs_read,
    input  logic             id_rt_read,
    input  logic [4:0]       ex_w_reg_addr,
    input  logic             ex_wd,
    input  logic             ex_is_load,
    input  logic             ex_multi_req,
    input  logic [CNT_W-1:0] ex_multi_cycles,
    input  logic             excp_flush,
    output logic [4:0]       stall,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             flush,
    output logic             ex_multi_done,
    output logic [31:0]      stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cycles_q;
    logic             load_use;
    logic             multi_stall;

    assign load_use = ex_is_load && ex_wd && (ex_w_reg_addr != 5'd0) &&
                      ((id_rs_read && (id_rs_addr == ex_w_reg_addr)) ||
                       (id_rt_read && (id_rt_addr == ex_w_reg_addr)));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        multi_stall   = 1'b0;
        stall         = 5'b00000;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        flush         = 1'b0;
        ex_multi_done = 1'b0;

        if (excp_flush) begin
            flush   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ex_multi_req) begin
                        if (ex_multi_cycles <= CNT_W'(1)) begin
                            ex_multi_done = 1'b1;
                        end else if (ex_multi_cycles == CNT_W'(2)) begin
                            multi_stall = 1'b1;
                            state_d     = DONE;
                        end else begin
                            // Entry cycle and the final DONE cycle are not counted by cnt.
                            multi_stall = 1'b1;
                            cnt_d       = ex_multi_cycles - CNT_W'(3);
                            state_d     = BUSY;
                        end
                    end
                end
                BUSY: begin
                    multi_stall = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    ex_multi_done = 1'b1;
                    state_d       = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (multi_stall) begin
                stall         = 5'b00111;
                ex_mem_bubble = 1'b1;
            end else if (load_use) begin
                stall        = 5'b00011;
                id_ex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall[0] && !flush && (stall_cycles_q != 32'hFFFF_FFFF)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus a random run against a cycle-count reference model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs_addr, id_rt_addr, ex_w_reg_addr;
    logic        id_rs_read, id_rt_read, ex_wd, ex_is_load, ex_multi_req, excp_flush;
    logic [5:0]  ex_multi_cycles;
    logic [4:0]  stall;
    logic        id_ex_bubble, ex_mem_bubble, flush, ex_multi_done;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int sc_exp = 0;

    pipe_ctrl #(.CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_read(id_rs_read), .id_rt_read(id_rt_read),
        .ex_w_reg_addr(ex_w_reg_addr), .ex_wd(ex_wd), .ex_is_load(ex_is_load),
        .ex_multi_req(ex_multi_req), .ex_multi_cycles(ex_multi_cycles),
        .excp_flush(excp_flush),
        .stall(stall), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
        .flush(flush), .ex_multi_done(ex_multi_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; ex_w_reg_addr = 5'd0;
        id_rs_read = 1'b0; id_rt_read = 1'b0; ex_wd = 1'b0; ex_is_load = 1'b0;
        ex_multi_req = 1'b0; ex_multi_cycles = 6'd0; excp_flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #2;
        checks++; if ({stall, id_ex_bubble, ex_mem_bubble, flush, ex_multi_done} !== 9'd0) begin
            errors++; $display("FAIL reset_outputs got %b want 0", {stall, id_ex_bubble, ex_mem_bubble, flush, ex_multi_done});
        end
        checks++; if (stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_stall_cycles got %0d want 0", stall_cycles);
        end
        @(negedge clk); rst = 1'b1; sc_exp = 0;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle_inputs();
        ex_is_load = 1'b1; ex_wd = 1'b1; ex_w_reg_addr = 5'd8; id_rs_read = 1'b1; id_rs_addr = 5'd8;
        #1;
        checks++; if (stall !== 5'b00011 || id_ex_bubble !== 1'b1 || ex_mem_bubble !== 1'b0) begin
            errors++; $display("FAIL load_use_rs got stall=%b idb=%b emb=%b want 00011/1/0", stall, id_ex_bubble, ex_mem_bubble);
        end
        sc_exp++;
        @(negedge clk);
        checks++; if (stall_cycles !== 32'(sc_exp)) begin
            errors++; $display("FAIL load_use_count got %0d want %0d", stall_cycles, sc_exp);
        end
        idle_inputs();
        ex_is_load = 1'b1; ex_wd = 1'b1; ex_w_reg_addr = 5'd13; id_rt_read = 1'b1; id_rt_addr = 5'd13; id_rs_addr = 5'd13;
        #1;
        checks++; if (stall !== 5'b00011 || id_ex_bubble !== 1'b1) begin
            errors++; $display("FAIL load_use_rt got stall=%b idb=%b want 00011/1", stall, id_ex_bubble);
        end
        sc_exp++;
        @(negedge clk);
        idle_inputs();
        ex_is_load = 1'b1; ex_wd = 1'b0; ex_w_reg_addr = 5'd8; id_rs_read = 1'b1; id_rs_addr = 5'd8;
        #1;
        checks++; if (stall !== 5'b00000 || id_ex_bubble !== 1'b0) begin
            errors++; $display("FAIL load_no_wd got stall=%b idb=%b want 0/0", stall, id_ex_bubble);
        end
    endtask

    task automatic test_load_zero();
        @(negedge clk);
        idle_inputs();
        ex_is_load = 1'b1; ex_wd = 1'b1; ex_w_reg_addr = 5'd0; id_rs_read = 1'b1; id_rs_addr = 5'd0;
        #1;
        checks++; if (stall !== 5'b00000 || id_ex_bubble !== 1'b0 || ex_mem_bubble !== 1'b0) begin
            errors++; $display("FAIL load_r0 got stall=%b idb=%b emb=%b want 0/0/0", stall, id_ex_bubble, ex_mem_bubble);
        end
    endtask

    task automatic test_multi5();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c <= 5) begin
                ex_multi_req = 1'b1; ex_multi_cycles = 6'd5;
                // load-use match present throughout; the multi-cycle hold must win
                ex_is_load = (c <= 4); ex_wd = 1'b1; ex_w_reg_addr = 5'd4; id_rs_read = 1'b1; id_rs_addr = 5'd4;
            end
            #1;
            if (c <= 4) begin
                checks++; if (stall !== 5'b00111 || ex_mem_bubble !== 1'b1 || id_ex_bubble !== 1'b0 || ex_multi_done !== 1'b0) begin
                    errors++; $display("FAIL multi5_stall c%0d got stall=%b emb=%b idb=%b done=%b want 00111/1/0/0", c, stall, ex_mem_bubble, id_ex_bubble, ex_multi_done);
                end
                sc_exp++;
            end else if (c == 5) begin
                checks++; if (stall !== 5'b00000 || ex_multi_done !== 1'b1) begin
                    errors++; $display("FAIL multi5_done got stall=%b done=%b want 0/1", stall, ex_multi_done);
                end
            end else begin
                checks++; if (stall !== 5'b00000 || ex_multi_done !== 1'b0) begin
                    errors++; $display("FAIL multi5_idle got stall=%b done=%b want 0/0", stall, ex_multi_done);
                end
                checks++; if (stall_cycles !== 32'(sc_exp)) begin
                    errors++; $display("FAIL multi5_count got %0d want %0d", stall_cycles, sc_exp);
                end
            end
        end
    endtask

    task automatic test_n1_n2();
        @(negedge clk);
        idle_inputs(); ex_multi_req = 1'b1; ex_multi_cycles = 6'd1;
        #1;
        checks++; if (stall !== 5'b00000 || ex_multi_done !== 1'b1) begin
            errors++; $display("FAIL n1 got stall=%b done=%b want 0/1", stall, ex_multi_done);
        end
        @(negedge clk);
        idle_inputs(); ex_multi_req = 1'b1; ex_multi_cycles = 6'd2;
        #1;
        checks++; if (stall !== 5'b00111 || ex_multi_done !== 1'b0) begin
            errors++; $display("FAIL n2_c1 got stall=%b done=%b want 00111/0", stall, ex_multi_done);
        end
        sc_exp++;
        @(negedge clk);
        #1;
        checks++; if (stall !== 5'b00000 || ex_multi_done !== 1'b1) begin
            errors++; $display("FAIL n2_c2 got stall=%b done=%b want 0/1", stall, ex_multi_done);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (ex_multi_done !== 1'b0 || stall_cycles !== 32'(sc_exp)) begin
            errors++; $display("FAIL n2_after got done=%b cnt=%0d want 0/%0d", ex_multi_done, stall_cycles, sc_exp);
        end
    endtask

    task automatic test_flush_abort();
        int base;
        base = sc_exp;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c <= 3) begin
                ex_multi_req = 1'b1; ex_multi_cycles = 6'd6;
            end
            excp_flush = (c == 3);
            #1;
            if (c <= 2) begin
                sc_exp++;
            end else if (c == 3) begin
                checks++; if (flush !== 1'b1 || stall !== 5'b00000 || ex_mem_bubble !== 1'b0 || ex_multi_done !== 1'b0) begin
                    errors++; $display("FAIL flush_cycle got flush=%b stall=%b emb=%b done=%b want 1/0/0/0", flush, stall, ex_mem_bubble, ex_multi_done);
                end
            end else begin
                checks++; if (flush !== 1'b0 || stall !== 5'b00000 || ex_multi_done !== 1'b0) begin
                    errors++; $display("FAIL flush_next got flush=%b stall=%b done=%b want 0/0/0", flush, stall, ex_multi_done);
                end
                checks++; if (stall_cycles - 32'(base) !== 32'd2) begin
                    errors++; $display("FAIL flush_count got %0d want 2", stall_cycles - 32'(base));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            idle_inputs(); ex_multi_req = 1'b1; ex_multi_cycles = 6'd10;
        end
        @(posedge clk);
        #2;
        checks++; if (stall_cycles === 32'd0) begin
            errors++; $display("FAIL reset_mid_pre got %0d want nonzero", stall_cycles);
        end
        rst = 1'b0; idle_inputs();
        #1;
        checks++; if (stall_cycles !== 32'd0 || stall !== 5'b00000 || ex_multi_done !== 1'b0 || ex_mem_bubble !== 1'b0) begin
            errors++; $display("FAIL reset_mid got cnt=%0d stall=%b done=%b emb=%b want 0/0/0/0", stall_cycles, stall, ex_multi_done, ex_mem_bubble);
        end
        sc_exp = 0;
        @(negedge clk); rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            #1;
            checks++; if (ex_multi_done !== 1'b0 || stall !== 5'b00000) begin
                errors++; $display("FAIL reset_mid_after c%0d got done=%b stall=%b want 0/0", c, ex_multi_done, stall);
            end
        end
    endtask

    task automatic test_random();
        int   op_left;
        logic mstall, edone, lu;
        logic [4:0] e_stall;
        op_left = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
            ex_w_reg_addr = 5'($urandom_range(0, 3));
            id_rs_read = 1'($urandom); id_rt_read = 1'($urandom);
            ex_wd = 1'($urandom); ex_is_load = 1'($urandom);
            if (op_left == 0) begin
                ex_multi_req = ($urandom_range(0, 3) == 0);
                ex_multi_cycles = 6'($urandom_range(0, 12));
            end
            if (op_left == 1) ex_is_load = 1'b0;
            excp_flush = ($urandom_range(0, 15) == 0);
            #1;
            mstall = !excp_flush && ((op_left == 0 && ex_multi_req && ex_multi_cycles >= 6'd2) || op_left >= 2);
            edone  = !excp_flush && ((op_left == 0 && ex_multi_req && ex_multi_cycles <= 6'd1) || op_left == 1);
            lu     = !excp_flush && !mstall && ex_is_load && ex_wd && ex_w_reg_addr != 5'd0 &&
                     ((id_rs_read && id_rs_addr == ex_w_reg_addr) || (id_rt_read && id_rt_addr == ex_w_reg_addr));
            e_stall = mstall ? 5'b00111 : (lu ? 5'b00011 : 5'b00000);
            checks++; if ({stall, id_ex_bubble, ex_mem_bubble, flush, ex_multi_done} !== {e_stall, lu, mstall, excp_flush, edone}) begin
                errors++; $display("FAIL rand_out i%0d got %b want %b", i,
                    {stall, id_ex_bubble, ex_mem_bubble, flush, ex_multi_done}, {e_stall, lu, mstall, excp_flush, edone});
            end
            checks++; if (stall_cycles !== 32'(sc_exp)) begin
                errors++; $display("FAIL rand_count i%0d got %0d want %0d", i, stall_cycles, sc_exp);
            end
            if (excp_flush) op_left = 0;
            else if (op_left > 0) op_left--;
            else if (ex_multi_req && ex_multi_cycles >= 6'd2) op_left = int'(ex_multi_cycles) - 1;
            if (e_stall[0]) sc_exp++;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_zero();
        test_multi5();
        test_n1_n2();
        test_flush_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
